// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, FSM state encoding and decode helpers.
// Used by the execution unit, the control logic and the operand selector.
package alu_pkg;

  localparam logic [6:0] OP_ADD    = 7'b0000000;
  localparam logic [6:0] OP_SUB    = 7'b0000001;
  localparam logic [6:0] OP_AND    = 7'b0000010;
  localparam logic [6:0] OP_XOR    = 7'b0000011;
  localparam logic [6:0] OP_ADDI   = 7'b0000100;
  localparam logic [6:0] OP_COMPI  = 7'b0000101;
  localparam logic [6:0] OP_SHLL   = 7'b0100000;
  localparam logic [6:0] OP_SHRL   = 7'b0100001;
  localparam logic [6:0] OP_SHRA   = 7'b0100010;
  localparam logic [6:0] OP_LWADDR = 7'b0110000;
  localparam logic [6:0] OP_SWADDR = 7'b0110001;
  localparam logic [6:0] OP_MUL    = 7'b1000000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MUL   = 2'd2
  } alu_state_e;

  function automatic logic is_shift_op(input logic [6:0] op);
    return (op == OP_SHLL) || (op == OP_SHRL) || (op == OP_SHRA);
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between the issue logic (master) and the ALU (slave).
interface alu_exec_unit_if;

  logic        start;
  logic [31:0] input1;
  logic [31:0] input2;
  logic [6:0]  aluOp;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        carry;
  logic        zero;
  logic        sign;
  logic        overflow;
  logic        illegalOp;

  modport master (
    output start, input1, input2, aluOp,
    input  busy, done, result, carry, zero, sign, overflow, illegalOp
  );

  modport slave (
    input  start, input1, input2, aluOp,
    output busy, done, result, carry, zero, sign, overflow, illegalOp
  );

endinterface

// File: rtl/alu_mult_seq.sv
// 32-step shift-add unsigned multiplier; only instantiated when ALU_MULT_EN is defined.
// last is high during the final step; product shows the value being loaded on that step.
module alu_mult_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        last,
  output logic [63:0] product
);

  logic [63:0] prod_q, prod_d;
  logic [31:0] mcand_q, mcand_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [32:0] partial;

  // Upper half accumulates the multiplicand while the multiplier drains out of the lower half.
  always_comb begin
    prod_d  = prod_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    partial = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, mcand_q} : 33'd0);
    if (load) begin
      prod_d  = {32'd0, b};
      mcand_d = a;
      cnt_d   = 6'd32;
    end else if (cnt_q != 6'd0) begin
      prod_d = {partial, prod_q[31:1]};
      cnt_d  = cnt_q - 6'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q  <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
    end else begin
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
    end
  end

  assign last    = (cnt_q == 6'd1);
  assign product = prod_d;

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle add/sub/logic, one-bit-per-cycle shifts and,
// when ALU_MULT_EN is defined, a 32-cycle sequential multiply (otherwise MUL is illegal).
module alu_exec_unit
  import alu_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  alu_exec_unit_if.slave bus
);

  alu_state_e  state_q, state_d;
  logic [31:0] result_q, result_d;
  logic        carry_q, carry_d, zero_q, zero_d, sign_q, sign_d;
  logic        ovf_q, ovf_d, illegal_q, illegal_d, done_q, done_d;
  logic [31:0] shift_q, shift_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [6:0]  op_q, op_d;

  logic [4:0]  shamt;
  logic        sub_sel;
  logic [31:0] add_a, add_b;
  logic [32:0] sum;
  logic        add_ovf;
  logic [31:0] step_val;
  logic        step_out;
  logic        fin, c_val, v_val, ill_val;
  logic [31:0] res_val;

`ifdef ALU_MULT_EN
  logic        mul_load, mul_last;
  logic [63:0] mul_prod;

  alu_mult_seq u_mult (
    .clk     (clk),
    .rst     (rst),
    .load    (mul_load),
    .a       (bus.input1),
    .b       (bus.input2),
    .last    (mul_last),
    .product (mul_prod)
  );
`endif

  assign shamt = bus.input2[4:0];

  // Subtraction is A + ~B + 1; COMPI forces A to zero so the same adder gives 0 - B.
  always_comb begin
    sub_sel = (bus.aluOp == OP_SUB) || (bus.aluOp == OP_COMPI);
    add_a   = (bus.aluOp == OP_COMPI) ? 32'd0 : bus.input1;
    add_b   = sub_sel ? ~bus.input2 : bus.input2;
    sum     = {1'b0, add_a} + {1'b0, add_b} + {32'd0, sub_sel};
    add_ovf = (add_a[31] == add_b[31]) && (sum[31] != add_a[31]);
  end

  always_comb begin
    step_val = shift_q;
    step_out = 1'b0;
    case (op_q)
      OP_SHLL: {step_out, step_val} = {shift_q, 1'b0};
      OP_SHRL: {step_val, step_out} = {1'b0, shift_q};
      default: {step_val, step_out} = {shift_q[31], shift_q};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start && is_shift_op(bus.aluOp) && (shamt != 5'd0)) state_d = SHIFT;
`ifdef ALU_MULT_EN
        if (bus.start && (bus.aluOp == OP_MUL)) state_d = MUL;
`endif
      end
      SHIFT: if (cnt_q == 5'd1) state_d = IDLE;
`ifdef ALU_MULT_EN
      MUL:   if (mul_last) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // fin marks the cycle whose edge publishes result and flags together with done.
  always_comb begin
    fin     = 1'b0;
    res_val = '0;
    c_val   = 1'b0;
    v_val   = 1'b0;
    ill_val = 1'b0;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
`ifdef ALU_MULT_EN
    mul_load = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d = bus.aluOp;
          case (bus.aluOp)
            OP_ADD, OP_ADDI, OP_LWADDR, OP_SWADDR, OP_SUB, OP_COMPI: begin
              fin     = 1'b1;
              res_val = sum[31:0];
              c_val   = sum[32];
              v_val   = add_ovf;
            end
            OP_AND: begin
              fin     = 1'b1;
              res_val = bus.input1 & bus.input2;
            end
            OP_XOR: begin
              fin     = 1'b1;
              res_val = bus.input1 ^ bus.input2;
            end
            OP_SHLL, OP_SHRL, OP_SHRA: begin
              if (shamt == 5'd0) begin
                fin     = 1'b1;
                res_val = bus.input1;
              end else begin
                shift_d = bus.input1;
                cnt_d   = shamt;
              end
            end
`ifdef ALU_MULT_EN
            OP_MUL: mul_load = 1'b1;
`endif
            default: begin
              fin     = 1'b1;
              ill_val = 1'b1;
            end
          endcase
        end
      end
      SHIFT: begin
        shift_d = step_val;
        cnt_d   = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          fin     = 1'b1;
          res_val = step_val;
          c_val   = step_out;
        end
      end
`ifdef ALU_MULT_EN
      MUL: begin
        if (mul_last) begin
          fin     = 1'b1;
          res_val = mul_prod[31:0];
          v_val   = |mul_prod[63:32];
        end
      end
`endif
      default: ;
    endcase

    done_d    = fin;
    result_d  = fin ? res_val : result_q;
    carry_d   = fin ? c_val : carry_q;
    ovf_d     = fin ? v_val : ovf_q;
    illegal_d = fin ? ill_val : illegal_q;
    zero_d    = fin ? (!ill_val && (res_val == 32'd0)) : zero_q;
    sign_d    = fin ? res_val[31] : sign_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q  <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      sign_q    <= 1'b0;
      ovf_q     <= 1'b0;
      illegal_q <= 1'b0;
      done_q    <= 1'b0;
      shift_q   <= '0;
      cnt_q     <= '0;
      op_q      <= '0;
    end else begin
      result_q  <= result_d;
      carry_q   <= carry_d;
      zero_q    <= zero_d;
      sign_q    <= sign_d;
      ovf_q     <= ovf_d;
      illegal_q <= illegal_d;
      done_q    <= done_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;
  assign bus.sign      = sign_q;
  assign bus.overflow  = ovf_q;
  assign bus.illegalOp = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed corner cases plus random operations
// compared against an arithmetic reference model of the operation table.
module tb_alu_exec_unit;
  import alu_pkg::*;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  alu_exec_unit_if bus ();

  alu_exec_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Reference model: flags packed as {carry, zero, sign, overflow, illegalOp}; lat = busy cycles.
  task automatic modelOp(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic [4:0] flags, output int lat);
    longint sa, sb, t;
    longint unsigned prod;
    int k;
    logic c, v, ill;
    sa = $signed(a);
    sb = $signed(b);
    k = int'(b[4:0]);
    c = 1'b0; v = 1'b0; ill = 1'b0; lat = 0; r = 32'd0;
    case (op)
      OP_ADD, OP_ADDI, OP_LWADDR, OP_SWADDR: begin
        r = a + b;
        c = ({32'd0, a} + {32'd0, b}) > 64'hFFFF_FFFF;
        t = sa + sb;
        v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      OP_SUB: begin
        r = a - b;
        c = (a >= b);
        t = sa - sb;
        v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      OP_COMPI: begin
        r = 32'd0 - b;
        c = (b == 32'd0);
        t = -sb;
        v = (t > 64'sd2147483647);
      end
      OP_AND: r = a & b;
      OP_XOR: r = a ^ b;
      OP_SHLL: begin
        r = a << k; lat = k;
        if (k > 0) c = a[32 - k];
      end
      OP_SHRL: begin
        r = a >> k; lat = k;
        if (k > 0) c = a[k - 1];
      end
      OP_SHRA: begin
        r = $unsigned($signed(a) >>> k); lat = k;
        if (k > 0) c = a[k - 1];
      end
`ifdef ALU_MULT_EN
      OP_MUL: begin
        prod = {32'd0, a} * {32'd0, b};
        r = prod[31:0];
        v = (prod[63:32] != 32'd0);
        lat = 32;
      end
`endif
      default: ill = 1'b1;
    endcase
    flags = {c, (!ill && r == 32'd0), r[31], v, ill};
  endtask

  task automatic applyStimulus(input string tag, input logic [6:0] op, input logic [31:0] a,
                               input logic [31:0] b, input bit injectBusy);
    logic [31:0] expR;
    logic [4:0]  expF;
    int expLat, cycles;
    modelOp(op, a, b, expR, expF, expLat);
    @(negedge clk);
    bus.start = 1'b1; bus.aluOp = op; bus.input1 = a; bus.input2 = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (expLat > 0) checkOutput({tag, "_busy"}, 64'(bus.busy), 64'd1);
    cycles = 0;
    while (!bus.done && cycles < 40) begin
      if (injectBusy && cycles == 0) begin
        bus.start = 1'b1; bus.aluOp = OP_ADD;
        bus.input1 = $urandom; bus.input2 = $urandom;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      cycles++;
    end
    checkOutput({tag, "_lat"}, 64'(cycles), 64'(expLat));
    checkOutput({tag, "_busyend"}, 64'(bus.busy), 64'd0);
    checkOutput({tag, "_result"}, 64'(bus.result), 64'(expR));
    checkOutput({tag, "_flags"}, 64'({bus.carry, bus.zero, bus.sign, bus.overflow, bus.illegalOp}), 64'(expF));
    if (injectBusy) begin
      @(posedge clk); #1;
      checkOutput({tag, "_nodone"}, 64'(bus.done), 64'd0);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, 64'(bus.busy), 64'd0);
    checkOutput({tag, "_done"}, 64'(bus.done), 64'd0);
    checkOutput({tag, "_result"}, 64'(bus.result), 64'd0);
    checkOutput({tag, "_flags"}, 64'({bus.carry, bus.zero, bus.sign, bus.overflow, bus.illegalOp}), 64'd0);
  endtask

  logic [6:0] opList [12] = '{OP_ADD, OP_ADDI, OP_LWADDR, OP_SWADDR, OP_SUB, OP_COMPI,
                              OP_AND, OP_XOR, OP_SHLL, OP_SHRL, OP_SHRA, OP_MUL};

  initial begin
    int doneSeen;
    logic [6:0] op;
    logic [31:0] a, b;
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.aluOp = '0; bus.input1 = '0; bus.input2 = '0;
    repeat (2) @(posedge clk);
    #1 checkAllZero("por");
    @(negedge clk);
    rst = 1'b0;

    applyStimulus("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'd1, 1'b0);
    applyStimulus("sub_eq", OP_SUB, 32'd5, 32'd5, 1'b0);
    applyStimulus("compi", OP_COMPI, 32'h1234_5678, 32'd1, 1'b0);
    applyStimulus("shra4", OP_SHRA, 32'h8000_0001, 32'd4, 1'b1);
    applyStimulus("shll0", OP_SHLL, 32'hDEAD_BEEF, 32'd0, 1'b0);
    applyStimulus("illegal", 7'b1111111, 32'hFFFF_FFFF, 32'h1, 1'b0);
    applyStimulus("mul", OP_MUL, 32'h0001_0000, 32'h0001_0000, 1'b0);
    applyStimulus("shll31", OP_SHLL, 32'h0000_0003, 32'd31, 1'b0);
    applyStimulus("addi", OP_ADDI, 32'hFFFF_FFFF, 32'd1, 1'b0);

    applyStimulus("pre_rst", OP_ADD, 32'h7FFF_FFFF, 32'd1, 1'b0);
    @(negedge clk);
    bus.start = 1'b1; bus.aluOp = OP_SHRL; bus.input1 = 32'hF0F0_1234; bus.input2 = 32'd10;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1 checkAllZero("midrst");
    @(negedge clk);
    rst = 1'b0;
    doneSeen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (bus.done) doneSeen++;
    end
    checkOutput("midrst_nodone", 64'(doneSeen), 64'd0);
    applyStimulus("post_rst", OP_ADD, 32'd100, 32'd23, 1'b0);

    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 9) == 0) op = 7'($urandom);
      else op = opList[$urandom_range(0, 11)];
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      applyStimulus("rand", op, a, b, ($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
